matrix_merge_64_col: RTL and testbench



---
 rtl/matrix_pkg.sv | 23 ++
 rtl/matrix_merge_64_col.sv | 73 +++++++
 tb/tb_matrix_merge_64_col.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared sizing, FSM encoding and slice addressing for the column-block
// gather path that rebuilds a 64x64 matrix from four 64x16 column blocks.
package matrix_pkg;

   localparam int DW    = 16;
   localparam int N     = 64;
   localparam int NB    = 4;
   localparam int BLK_W = N * N * DW / NB;
   localparam int MAT_W = N * N * DW;
   localparam int CNT_W = $clog2(NB);
   localparam int IDX_W = $clog2(MAT_W);

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } state_t;

   // Block 0 occupies the most significant slice, matching the split stage.
   function automatic logic [IDX_W-1:0] slice_base(input logic [CNT_W-1:0] blk);
      return IDX_W'((NB - 1 - int'(blk)) * BLK_W);
   endfunction

endpackage

// File: rtl/matrix_merge_64_col.sv
// Gathers four signed column blocks into one registered 64x64 matrix word
// and hands it downstream with a valid/ready handshake.
module matrix_merge_64_col
   import matrix_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [BLK_W-1:0] in_block,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [MAT_W-1:0] Matrix,
   output logic [CNT_W-1:0]        blk_cnt
);

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          blk_cnt_q, blk_cnt_d;
   logic                      out_valid_q, out_valid_d;
   logic signed [MAT_W-1:0]   matrix_q, matrix_d;
   logic                      last_blk;

   assign last_blk = (blk_cnt_q == CNT_W'(NB - 1));

   always_comb begin
      state_d     = state_q;
      blk_cnt_d   = blk_cnt_q;
      out_valid_d = out_valid_q;
      matrix_d    = matrix_q;
      if (clr) begin
         state_d     = COLLECT;
         blk_cnt_d   = '0;
         out_valid_d = 1'b0;
         matrix_d    = '0;
      end else if (state_q == FULL) begin
         // Release the matrix only; input acceptance resumes on the next cycle.
         if (out_ready) begin
            state_d     = COLLECT;
            out_valid_d = 1'b0;
         end
      end else if (in_valid) begin
         matrix_d[slice_base(blk_cnt_q) +: BLK_W] = in_block;
         if (last_blk) begin
            blk_cnt_d   = '0;
            state_d     = FULL;
            out_valid_d = 1'b1;
         end else begin
            blk_cnt_d = blk_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= COLLECT;
         blk_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         matrix_q    <= '0;
      end else begin
         state_q     <= state_d;
         blk_cnt_q   <= blk_cnt_d;
         out_valid_q <= out_valid_d;
         matrix_q    <= matrix_d;
      end
   end

   assign in_ready  = (state_q == COLLECT);
   assign out_valid = out_valid_q;
   assign Matrix    = matrix_q;
   assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_matrix_merge_64_col.sv
// Scenario bench for matrix_merge_64_col: expected matrices are built by
// concatenating the blocks of each assembly, block 0 most significant.
module tb_matrix_merge_64_col;
   import matrix_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    clr;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [BLK_W-1:0] in_block;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [MAT_W-1:0] Matrix;
   logic [CNT_W-1:0]        blk_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [MAT_W-1:0] exp_mat;

   matrix_merge_64_col dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_block  (in_block),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Matrix    (Matrix),
      .blk_cnt   (blk_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [BLK_W-1:0] fill_blk(input logic [DW-1:0] v);
      logic [BLK_W-1:0] r;
      for (int i = 0; i < BLK_W / DW; i++) r[i*DW +: DW] = v;
      return r;
   endfunction

   function automatic logic [BLK_W-1:0] signed_blk();
      logic [BLK_W-1:0] r;
      for (int i = 0; i < BLK_W / DW; i++) r[i*DW +: DW] = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
      return r;
   endfunction

   function automatic logic [BLK_W-1:0] rand_blk();
      logic [BLK_W-1:0] r;
      for (int i = 0; i < BLK_W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Index of the first differing element, used only to keep FAIL lines short.
   function automatic int first_diff(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
      for (int i = 0; i < MAT_W / DW; i++) if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one block and waits (bounded) for it to be taken.
   task automatic push_block(input logic [BLK_W-1:0] blk, input int gap, output bit ok);
      ok = 1'b0;
      in_valid = 1'b0;
      repeat (gap) tick();
      in_valid = 1'b1;
      in_block = blk;
      for (int c = 0; c < 20; c++) begin
         if (in_ready) begin
            tick();
            ok = 1'b1;
            break;
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_block = '0;
      repeat (2) tick();
      n_checks++; if (Matrix !== '0) begin n_fail++; $display("FAIL reset_matrix: element %0d nonzero", first_diff(Matrix, '0)); end
      n_checks++; if (blk_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_blk_cnt: got %0d want 0", blk_cnt); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      #3 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fill();
      exp_mat = {fill_blk(16'h0001), fill_blk(16'h0002), fill_blk(16'h0003), fill_blk(16'h0004)};
      in_valid = 1'b1;
      for (int k = 0; k < NB; k++) begin
         in_block = fill_blk(16'(k + 1));
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready[%0d]: got %b want 1", k, in_ready); end
         n_checks++; if (blk_cnt !== 2'(k)) begin n_fail++; $display("FAIL fill_blk_cnt[%0d]: got %0d want %0d", k, blk_cnt, k); end
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_early_valid[%0d]: got %b want 0", k, out_valid); end
         tick();
      end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_out_valid: got %b want 1", out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready_full: got %b want 0", in_ready); end
      n_checks++; if (blk_cnt !== 2'd0) begin n_fail++; $display("FAIL fill_blk_cnt_wrap: got %0d want 0", blk_cnt); end
      n_checks++; if (Matrix !== exp_mat) begin n_fail++; $display("FAIL fill_matrix: element %0d got %h want %h", first_diff(Matrix, exp_mat), Matrix[first_diff(Matrix, exp_mat)*DW +: DW], exp_mat[first_diff(Matrix, exp_mat)*DW +: DW]); end
   endtask

   task automatic test_backpressure();
      in_valid  = 1'b1;
      in_block  = fill_blk(16'hBEEF);
      out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || blk_cnt !== 2'd0) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got ov=%b ir=%b cnt=%0d want ov=1 ir=0 cnt=0", c, out_valid, in_ready, blk_cnt);
         end
         n_checks++; if (Matrix !== exp_mat) begin n_fail++; $display("FAIL bp_matrix[%0d]: element %0d changed", c, first_diff(Matrix, exp_mat)); end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      n_checks++; if (Matrix !== exp_mat) begin n_fail++; $display("FAIL bp_matrix_kept: element %0d changed", first_diff(Matrix, exp_mat)); end
   endtask

   task automatic test_gapped();
      logic [BLK_W-1:0] blks [NB];
      bit ok;
      for (int k = 0; k < NB; k++) blks[k] = signed_blk();
      exp_mat = {blks[0], blks[1], blks[2], blks[3]};
      for (int k = 0; k < NB; k++) begin
         push_block(blks[k], $urandom_range(0, 3), ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL gap_accept[%0d]: got timeout want accept", k); end
         n_checks++; if (out_valid !== (k == NB - 1)) begin n_fail++; $display("FAIL gap_out_valid[%0d]: got %b want %b", k, out_valid, (k == NB - 1)); end
      end
      n_checks++; if (Matrix !== exp_mat) begin n_fail++; $display("FAIL gap_matrix: element %0d got %h want %h", first_diff(Matrix, exp_mat), Matrix[first_diff(Matrix, exp_mat)*DW +: DW], exp_mat[first_diff(Matrix, exp_mat)*DW +: DW]); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_clr();
      bit ok;
      for (int k = 0; k < 2; k++) begin
         push_block(rand_blk(), 0, ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL clr_pre_accept[%0d]: got timeout want accept", k); end
      end
      n_checks++; if (blk_cnt !== 2'd2) begin n_fail++; $display("FAIL clr_pre_cnt: got %0d want 2", blk_cnt); end
      // clr must win over a simultaneous accept
      in_valid = 1'b1;
      in_block = rand_blk();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      in_valid = 1'b0;
      n_checks++; if (blk_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d want 0", blk_cnt); end
      n_checks++; if (Matrix !== '0) begin n_fail++; $display("FAIL clr_matrix: element %0d nonzero", first_diff(Matrix, '0)); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_out_valid: got %b want 0", out_valid); end
      exp_mat = {NB{fill_blk(16'h00A5)}};
      for (int k = 0; k < NB; k++) begin
         push_block(fill_blk(16'h00A5), 0, ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL clr_post_accept[%0d]: got timeout want accept", k); end
      end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_post_valid: got %b want 1", out_valid); end
      n_checks++; if (Matrix !== exp_mat) begin n_fail++; $display("FAIL clr_post_matrix: element %0d got %h want 00a5", first_diff(Matrix, exp_mat), Matrix[first_diff(Matrix, exp_mat)*DW +: DW]); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      bit ok;
      bit saw_valid;
      for (int k = 0; k < 3; k++) begin
         push_block(fill_blk(16'h5A5A), 0, ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL ar_accept[%0d]: got timeout want accept", k); end
      end
      n_checks++; if (blk_cnt !== 2'd3) begin n_fail++; $display("FAIL ar_pre_cnt: got %0d want 3", blk_cnt); end
      in_valid = 1'b1;
      in_block = fill_blk(16'h5A5A);
      #3 rst_n = 1'b0;
      #1;
      n_checks++; if (Matrix !== '0) begin n_fail++; $display("FAIL ar_matrix: element %0d nonzero", first_diff(Matrix, '0)); end
      n_checks++; if (blk_cnt !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL ar_ctrl: got cnt=%0d ov=%b ir=%b want cnt=0 ov=0 ir=1", blk_cnt, out_valid, in_ready);
      end
      in_valid = 1'b0;
      tick();
      #3 rst_n = 1'b1;
      saw_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (out_valid) saw_valid = 1'b1;
      end
      n_checks++; if (saw_valid) begin n_fail++; $display("FAIL ar_no_pulse: got out_valid pulse want none"); end
   endtask

   task automatic test_back_to_back();
      logic [BLK_W-1:0] a_blk;
      logic [BLK_W-1:0] b_blk;
      int  idx;
      int  t1;
      int  t2;
      bit  rdy;
      bit  prev_ov;
      a_blk = fill_blk(16'h1111);
      b_blk = fill_blk(16'h2222);
      idx = 0; t1 = -1; t2 = -1; prev_ov = 1'b0;
      out_ready = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         in_block = (idx < NB) ? a_blk : b_blk;
         in_valid = (idx < 2 * NB);
         rdy = in_ready;
         tick();
         if (rdy && in_valid) idx++;
         if (out_valid && !prev_ov) begin
            if (t1 < 0) t1 = c;
            else if (t2 < 0) t2 = c;
         end
         prev_ov = out_valid;
         if (t2 >= 0) break;
      end
      in_valid = 1'b0;
      n_checks++; if (t1 < 0 || t2 < 0) begin n_fail++; $display("FAIL b2b_timeout: got t1=%0d t2=%0d want both seen", t1, t2); end
      n_checks++; if (t2 - t1 !== 5) begin n_fail++; $display("FAIL b2b_period: got %0d want 5", t2 - t1); end
      exp_mat = {NB{b_blk}};
      n_checks++; if (Matrix !== exp_mat) begin n_fail++; $display("FAIL b2b_matrix: element %0d got %h want 2222", first_diff(Matrix, exp_mat), Matrix[first_diff(Matrix, exp_mat)*DW +: DW]); end
      tick();
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_backpressure();
      test_gapped();
      test_clr();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
